// File: rtl/rf_access_seq.sv
// Register-file access sequencer: fetch operands for one instruction, hand them to the ALU, write back the result.
// Latency: accept at edge 0, op_valid after edge 2; write-back on the edge after the result handshake (ZERO_REG_EN: r0 hardwired to zero).
// Backpressure: instr_ready only in IDLE; stalls indefinitely on op_ready/res_valid, holding operands stable.
module rf_access_seq #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 4,
    parameter logic [3:0]  NOWB_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [3:0]        op_code,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              rf_EN,
    output logic [1:0]        rf_RW,
    output logic [ADDR_W-1:0] rf_AA,
    output logic [ADDR_W-1:0] rf_BA,
    output logic [ADDR_W-1:0] rf_DA,
    output logic [DATA_W-1:0] rf_D,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        CAPT   = 3'd2,
        ISSUE  = 3'd3,
        RESULT = 3'd4,
        WRITE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [ADDR_W-1:0]   rb_q, rb_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   rf_d_q, rf_d_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rf_d_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rf_d_q   <= rf_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rf_d_d   = rf_d_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    opcode_d = instr[15:12];
                    rd_d     = instr[11:8];
                    ra_d     = instr[7:4];
                    rb_d     = instr[3:0];
                    state_d  = READ;
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                // rf_A/rf_B are valid now, one cycle after the read edge
                op_a_d = rf_A;
                op_b_d = rf_B;
`ifdef ZERO_REG_EN
                if (ra_q == '0) op_a_d = '0;
                if (rb_q == '0) op_b_d = '0;
`endif
                state_d = ISSUE;
            end
            ISSUE: begin
                if (op_ready) state_d = (opcode_q == NOWB_OP) ? IDLE : RESULT;
            end
            RESULT: begin
                if (res_valid) begin
                    rf_d_d  = res_data;
                    state_d = WRITE;
`ifdef ZERO_REG_EN
                    if (rd_q == '0) state_d = IDLE;
`endif
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset holds rf_EN high with RW=00 so the attached register file clears.
    always_comb begin
        instr_ready = (state_q == IDLE);
        op_valid    = (state_q == ISSUE);
        res_ready   = (state_q == RESULT);
        op_code     = opcode_q;
        op_a        = op_a_q;
        op_b        = op_b_q;
        rf_D        = rf_d_q;
        rf_EN       = rst || (state_q == READ) || (state_q == WRITE);
        rf_RW       = 2'b00;
        rf_AA       = '0;
        rf_BA       = '0;
        rf_DA       = '0;
        if (!rst && state_q == READ) begin
            rf_RW = 2'b10;
            rf_AA = ra_q;
            rf_BA = rb_q;
        end
        if (!rst && state_q == WRITE) begin
            rf_RW = 2'b01;
            rf_DA = rd_q;
        end
    end

endmodule

// File: tb/tb_rf_access_seq.sv
// Directed bench for rf_access_seq with a behavioural 16x16 register file attached.
module tb_rf_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [15:0] op_a, op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        rf_EN;
    logic [1:0]  rf_RW;
    logic [3:0]  rf_AA, rf_BA, rf_DA;
    logic [15:0] rf_D;
    logic [15:0] rf_A, rf_B;

    logic [15:0] mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    int          rw11_cnt = 0;
    int          wr_snap;

    always #5 clk = ~clk;

    rf_access_seq dut (
        .clk(clk), .rst(rst),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .rf_EN(rf_EN), .rf_RW(rf_RW), .rf_AA(rf_AA), .rf_BA(rf_BA),
        .rf_DA(rf_DA), .rf_D(rf_D), .rf_A(rf_A), .rf_B(rf_B)
    );

    // Register file: enable with RW=00 clears, 10 reads (output next cycle), 01 writes.
    always @(posedge clk) begin
        if (rf_EN) begin
            if (rf_RW == 2'b00) begin
                for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
            end else if (rf_RW == 2'b10) begin
                rf_A <= mem[rf_AA];
                rf_B <= mem[rf_BA];
            end else if (rf_RW == 2'b01) begin
                mem[rf_DA] <= rf_D;
            end
        end
    end

    always @(negedge clk) begin
        if (rf_EN && rf_RW == 2'b01) wr_cnt++;
        if (rf_RW == 2'b11) rw11_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in ISSUE with operands presented.
    task automatic send_instr(input logic [15:0] i);
        instr       = i;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic accept_ops();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic give_result(input logic [15:0] r);
        res_valid = 1'b1;
        res_data  = r;
        tick();
        res_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr = 16'h0; instr_valid = 1'b0; op_ready = 1'b0;
        res_valid = 1'b0; res_data = 16'h0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1111;
        #1;
        check("rst_en", {31'b0, rf_EN}, 32'd1);
        tick();
        check("rst_en_2", {31'b0, rf_EN}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("rst_rdy",  {31'b0, instr_ready}, 32'd1);
        check("rst_outs", {op_valid, res_ready, rf_EN, rf_RW, op_code, rf_AA, rf_BA, rf_DA},
              32'd0);
        check("rst_ops",  {op_a, op_b}, 32'd0);
        check("rst_rfd",  {16'b0, rf_D}, 32'd0);
        check("rst_clear", {16'b0, mem[5]}, 32'd0);

        // Basic operation with operand and result back-pressure
        mem[2] = 16'h1234; mem[3] = 16'h00FF;
        instr = 16'h1423; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("read_cmd", {rf_EN, rf_RW, rf_AA, rf_BA}, {23'b0, 1'b1, 2'b10, 4'd2, 4'd3});
        check("read_nrdy", {31'b0, instr_ready}, 32'd0);
        tick();
        check("capt_cmd", {rf_EN, rf_RW, op_valid}, 32'd0);
        tick();
        check("issue_vld", {31'b0, op_valid}, 32'd1);
        check("issue_ops", {op_a, op_b}, 32'h123400FF);
        check("issue_code", {28'b0, op_code}, 32'd1);
        instr = 16'h9999; instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall", {op_valid, rf_EN, op_code, op_a, op_b[9:0]},
                  {1'b1, 1'b0, 4'd1, 16'h1234, 10'h0FF});
        end
        instr_valid = 1'b0;
        accept_ops();
        check("result_rdy", {op_valid, res_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("res_wait", {res_ready, rf_EN}, 32'd2);
        end
        res_valid = 1'b1; res_data = 16'h1333;
        tick();
        res_valid = 1'b0;
        check("write_cmd", {rf_EN, rf_RW, rf_DA, rf_D}, {9'b0, 1'b1, 2'b01, 4'd4, 16'h1333});
        tick();
        check("write_done", {rf_EN, rf_RW, instr_ready}, 32'd1);
        check("write_mem", {16'b0, mem[4]}, 32'h1333);
        check("write_once", wr_cnt, 32'd1);

        // Read-after-write through r4
        send_instr(16'h2456);
        accept_ops();
        give_result(16'hBEEF);
        mem[1] = 16'h0042;
        send_instr(16'h3741);
        check("raw_a", {16'b0, op_a}, 32'hBEEF);
        check("raw_b", {16'b0, op_b}, 32'h0042);
        accept_ops();
        give_result(16'h0007);
        check("raw_wr", {16'b0, mem[7]}, 32'h0007);

        // No-write-back opcode
        wr_snap = wr_cnt;
        mem[1] = 16'hAAAA; mem[2] = 16'h5555;
        send_instr(16'hF512);
        check("nowb_ops", {op_a, op_b}, 32'hAAAA5555);
        check("nowb_code", {28'b0, op_code}, 32'hF);
        accept_ops();
        check("nowb_idle", {instr_ready, res_ready}, 32'd2);
        res_valid = 1'b1; res_data = 16'h6666;
        tick();
        tick();
        res_valid = 1'b0;
        check("nowb_nowr", wr_cnt, wr_snap);

        // Zero register behaviour
        mem[0] = 16'h7777; mem[1] = 16'h0042;
        wr_snap = wr_cnt;
        send_instr(16'h1001);
`ifdef ZERO_REG_EN
        check("r0_a", {16'b0, op_a}, 32'h0);
`else
        check("r0_a", {16'b0, op_a}, 32'h7777);
`endif
        check("r0_b", {16'b0, op_b}, 32'h0042);
        accept_ops();
        give_result(16'h5A5A);
`ifdef ZERO_REG_EN
        check("r0_nowr", wr_cnt, wr_snap);
        check("r0_keep", {16'b0, mem[0]}, 32'h7777);
`else
        check("r0_wr", wr_cnt, wr_snap + 1);
        check("r0_mem", {16'b0, mem[0]}, 32'h5A5A);
`endif
        check("r0_idle", {31'b0, instr_ready}, 32'd1);

        // Reset while waiting for the result
        wr_snap = wr_cnt;
        send_instr(16'h2789);
        accept_ops();
        check("mid_res", {31'b0, res_ready}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_en", {31'b0, rf_EN}, 32'd1);
        tick();
        rst = 1'b0;
        res_valid = 1'b1; res_data = 16'h4321;
        #1;
        check("mid_idle", {instr_ready, res_ready, op_valid}, 32'd4);
        tick();
        tick();
        res_valid = 1'b0;
        check("mid_nowr", wr_cnt, wr_snap);
        check("mid_ops", {op_a, op_b}, 32'd0);
        check("no_rw11", rw11_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
